// File: rtl/pd_peak_collector.sv
// pd_peak_collector: tags detected peaks with their column index and buffers the
// tagged records in a first-word fall-through FIFO drained over a valid/ready port.
// Also tracks the per-line accepted-peak count and a sticky overflow flag.
module pd_peak_collector #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned PIX_W  = 12,
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned PD_LAT = 0
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      start_act,
   input  logic                      line_end,
   input  logic                      vald_din,
   input  logic [PIX_W-1:0]          active_columns_start,
   input  logic                      peak_valid,
   input  logic [DATA_W-1:0]         peak_info,
   input  logic                      rd_ready,
   output logic                      rd_valid,
   output logic [PIX_W+DATA_W-1:0]   rd_data,
   output logic [7:0]                peak_cnt,
   output logic                      overflow,
   output logic [$clog2(DEPTH):0]    fifo_level
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned RW = PIX_W + DATA_W;

   typedef enum logic [0:0] {StIdle, StActive} state_e;

   state_e            state_q;
   logic [PIX_W-1:0]  col_cnt_q;
   logic [7:0]        peak_cnt_q;
   logic              overflow_q;

   logic [RW-1:0]     mem_q [DEPTH];
   logic [AW:0]       wr_ptr_q, wr_ptr_d;
   logic [AW:0]       rd_ptr_q, rd_ptr_d;
   logic              rd_valid_q, rd_valid_d;
   logic [RW-1:0]     rd_data_q, rd_data_d;

   logic              wr_req, wr_en, rd_pop, full;
   logic [PIX_W-1:0]  col_tag;
   logic [RW-1:0]     wr_data;

   // Write/read decode; the output register is fed from next-state pointers so it
   // always shows the head of the FIFO, forwarding a write that lands on the new head.
   always_comb begin
      wr_req    = peak_valid && (state_q == StActive);
      rd_pop    = rd_valid_q && rd_ready;
      full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      wr_en     = wr_req && (!full || rd_pop);
      col_tag   = col_cnt_q - PIX_W'(PD_LAT);
      wr_data   = {col_tag, peak_info};
      wr_ptr_d  = wr_ptr_q + (AW + 1)'(wr_en);
      rd_ptr_d  = rd_ptr_q + (AW + 1)'(rd_pop);
      rd_valid_d = (wr_ptr_d != rd_ptr_d);
      if (wr_en && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0])) begin
         rd_data_d = wr_data;
      end else begin
         rd_data_d = mem_q[rd_ptr_d[AW-1:0]];
      end
   end

   // Line FSM with column counter, per-line peak count and sticky overflow.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= StIdle;
         col_cnt_q  <= '0;
         peak_cnt_q <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (start_act) begin
            // Restart wins over line_end and over any same-cycle count/drop.
            state_q    <= StActive;
            col_cnt_q  <= active_columns_start;
            peak_cnt_q <= '0;
            overflow_q <= 1'b0;
         end else begin
            if (state_q == StActive && line_end) begin
               state_q <= StIdle;
            end
            if (state_q == StActive && vald_din) begin
               col_cnt_q <= col_cnt_q + 1'b1;
            end
            if (wr_en && peak_cnt_q != 8'hFF) begin
               peak_cnt_q <= peak_cnt_q + 8'd1;
            end
            if (wr_req && !wr_en) begin
               overflow_q <= 1'b1;
            end
         end
      end
   end

   // FIFO storage, pointers and registered read port.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
         end
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
      end
   end

   assign rd_valid   = rd_valid_q;
   assign rd_data    = rd_data_q;
   assign peak_cnt   = peak_cnt_q;
   assign overflow   = overflow_q;
   assign fifo_level = wr_ptr_q - rd_ptr_q;

endmodule

// File: tb/tb_pd_peak_collector.sv
// Scoreboard bench for pd_peak_collector: the driver keeps a queue-based model of
// the FIFO and line state; a negedge monitor compares DUT outputs against it.
module tb_pd_peak_collector;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned PIX_W  = 12;
   localparam int unsigned DEPTH  = 8;
   localparam int unsigned PD_LAT = 0;
   localparam int unsigned RW     = PIX_W + DATA_W;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic              start_act = 1'b0;
   logic              line_end = 1'b0;
   logic              vald_din = 1'b0;
   logic [PIX_W-1:0]  active_columns_start = '0;
   logic              peak_valid = 1'b0;
   logic [DATA_W-1:0] peak_info = '0;
   logic              rd_ready = 1'b0;
   logic              rd_valid;
   logic [RW-1:0]     rd_data;
   logic [7:0]        peak_cnt;
   logic              overflow;
   logic [3:0]        fifo_level;

   pd_peak_collector #(
      .DATA_W (DATA_W),
      .PIX_W  (PIX_W),
      .DEPTH  (DEPTH),
      .PD_LAT (PD_LAT)
   ) dut (
      .clk                  (clk),
      .reset_n              (reset_n),
      .start_act            (start_act),
      .line_end             (line_end),
      .vald_din             (vald_din),
      .active_columns_start (active_columns_start),
      .peak_valid           (peak_valid),
      .peak_info            (peak_info),
      .rd_ready             (rd_ready),
      .rd_valid             (rd_valid),
      .rd_data              (rd_data),
      .peak_cnt             (peak_cnt),
      .overflow             (overflow),
      .fifo_level           (fifo_level)
   );

   always #5 clk = ~clk;

   // Reference model state.
   logic [RW-1:0]    exp_q[$];
   bit               m_active;
   logic [PIX_W-1:0] m_col;
   int               m_cnt;
   bit               m_ovf;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // One clock of stimulus; the model advances with the DUT edge.
   task automatic cycle(input bit st, input bit le, input bit vd, input logic [PIX_W-1:0] acs,
                        input bit pv, input logic [DATA_W-1:0] pi, input bit rdy);
      bit wr_req, rd, acc;
      logic [RW-1:0] entry;
      start_act = st; line_end = le; vald_din = vd; active_columns_start = acs;
      peak_valid = pv; peak_info = pi; rd_ready = rdy;
      wr_req = pv && m_active;
      rd     = (exp_q.size() != 0) && rdy;
      acc    = wr_req && ((exp_q.size() < DEPTH) || rd);
      entry  = {PIX_W'(m_col - PIX_W'(PD_LAT)), pi};
      @(posedge clk);
      #1;
      if (acc) exp_q.push_back(entry);
      if (st) begin
         m_cnt = 0; m_ovf = 0; m_col = acs; m_active = 1;
      end else begin
         if (acc && m_cnt < 255) m_cnt++;
         if (wr_req && !acc) m_ovf = 1;
         if (m_active && vd) m_col = m_col + 1'b1;
         if (m_active && le) m_active = 0;
      end
   endtask

   task automatic idle(input bit rdy);
      cycle(0, 0, 0, '0, 0, '0, rdy);
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
      idle(0);
      chk("drain_empty", {63'd0, rd_valid}, 64'd0);
   endtask

   // Monitor: compare the DUT against the model, then retire a handshaken entry.
   always @(negedge clk) begin
      if (reset_n) begin
         chk("rd_valid", {63'd0, rd_valid}, {63'd0, exp_q.size() != 0});
         chk("fifo_level", {60'd0, fifo_level}, 64'(exp_q.size()));
         chk("peak_cnt", {56'd0, peak_cnt}, 64'(m_cnt));
         chk("overflow", {63'd0, overflow}, {63'd0, m_ovf});
         if (exp_q.size() != 0) begin
            chk("rd_data", {36'd0, rd_data}, {36'd0, exp_q[0]});
            if (rd_ready) void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      m_active = 0; m_col = '0; m_cnt = 0; m_ovf = 0;
      #12 reset_n = 1'b1;

      // Test 2: basic tag.
      cycle(1, 0, 0, 12'd100, 0, '0, 0);
      for (int i = 0; i < 5; i++) cycle(0, 0, 1, '0, 0, '0, 0);
      cycle(0, 0, 0, '0, 1, 16'h1234, 0);
      chk("t2_data", {36'd0, rd_data}, {36'd0, 12'd105, 16'h1234});
      chk("t2_cnt", {56'd0, peak_cnt}, 64'd1);
      drain();

      // Test 1: async reset with 3 entries held.
      for (int i = 0; i < 3; i++) cycle(0, 0, 1, '0, 1, 16'(i + 7), 0);
      chk("t1_level_pre", {60'd0, fifo_level}, 64'd3);
      start_act = 0; line_end = 0; vald_din = 0; peak_valid = 0; rd_ready = 0;
      #2 reset_n = 1'b0;
      #1;
      chk("t1_valid", {63'd0, rd_valid}, 64'd0);
      chk("t1_data", {36'd0, rd_data}, 64'd0);
      chk("t1_cnt", {56'd0, peak_cnt}, 64'd0);
      chk("t1_ovf", {63'd0, overflow}, 64'd0);
      chk("t1_level", {60'd0, fifo_level}, 64'd0);
      exp_q.delete(); m_active = 0; m_col = '0; m_cnt = 0; m_ovf = 0;
      #1 reset_n = 1'b1;
      idle(0);
      cycle(0, 0, 1, '0, 1, 16'hBEEF, 0);
      chk("t1_idle_after_rst", {60'd0, fifo_level}, 64'd0);

      // Test 3: overflow with no reads.
      cycle(1, 0, 0, 12'd10, 0, '0, 0);
      for (int i = 1; i <= 9; i++) cycle(0, 0, 1, '0, 1, 16'(16'h100 + i), 0);
      chk("t3_level", {60'd0, fifo_level}, 64'd8);
      chk("t3_ovf", {63'd0, overflow}, 64'd1);
      chk("t3_cnt", {56'd0, peak_cnt}, 64'd8);

      // Test 4: full with simultaneous read and write.
      cycle(0, 0, 0, '0, 1, 16'h4444, 1);
      chk("t4_level", {60'd0, fifo_level}, 64'd8);
      chk("t4_ovf", {63'd0, overflow}, 64'd1);
      chk("t4_cnt", {56'd0, peak_cnt}, 64'd9);
      drain();

      // Test 5: column wrap.
      cycle(1, 0, 0, 12'd4094, 0, '0, 0);
      for (int i = 0; i < 3; i++) cycle(0, 0, 1, '0, 0, '0, 0);
      cycle(0, 0, 0, '0, 1, 16'h0055, 0);
      chk("t5_tag", {52'd0, rd_data[RW-1:DATA_W]}, 64'd1);
      drain();

      // Test 6: IDLE peaks ignored; start_act with peak tags with old column.
      cycle(0, 1, 0, '0, 0, '0, 0);
      cycle(0, 0, 1, '0, 1, 16'h6666, 0);
      chk("t6_idle_level", {60'd0, fifo_level}, 64'd0);
      cycle(1, 0, 0, 12'd200, 0, '0, 0);
      cycle(0, 0, 1, '0, 0, '0, 0);
      cycle(1, 0, 1, 12'd300, 1, 16'h7777, 0);
      chk("t6_tag", {36'd0, rd_data}, {36'd0, 12'd201, 16'h7777});
      chk("t6_cnt", {56'd0, peak_cnt}, 64'd0);
      drain();

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         cycle($urandom_range(99) < 3, $urandom_range(99) < 3, $urandom_range(1) == 1,
               PIX_W'($urandom), $urandom_range(99) < 45, DATA_W'($urandom),
               $urandom_range(99) < 45);
      end
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
